// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM encoding, default region map and error constants for the data-side bus decoder.
package bus_pkg;
    localparam int MAX_SLV = 8;
    localparam int IDX_W   = $clog2(MAX_SLV);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] DMEM_BASE     = 32'h1000_0000;
    localparam logic [31:0] DMEM_MASK     = 32'hD000_0000;
    localparam logic [31:0] TBMAN_BASE    = 32'h8000_F000;
    localparam logic [31:0] TBMAN_MASK    = 32'hFFFF_F000;
    localparam logic [31:0] GPIO_BASE     = 32'h8000_2000;
    localparam logic [31:0] GPIO_MASK     = 32'hFFFF_F000;
    localparam logic [31:0] TIMER_BASE    = 32'h8000_1000;
    localparam logic [31:0] TIMER_MASK    = 32'hFFFF_F000;
    localparam logic [31:0] UART_BASE     = 32'h8000_0000;
    localparam logic [31:0] UART_MASK     = 32'hFFFF_F000;
    localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/bus_decoder_ctrl_if.sv
// bus_decoder_ctrl_if: CPU data-port request/response bundle seen by the decoder.
interface bus_decoder_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master(output req, we, addr, wdata, be, input ready, rdata, err);
    modport slave(input req, we, addr, wdata, be, output ready, rdata, err);
endinterface

// File: rtl/region_match.sv
// region_match: priority base/mask address match; the lowest-index hitting region wins.
module region_match
    import bus_pkg::*;
#(
    parameter int              N    = 5,
    parameter logic [N*32-1:0] BASE = '0,
    parameter logic [N*32-1:0] MASK = '0
) (
    input  logic [31:0]      addr,
    output logic [N-1:0]     hit,
    output logic [IDX_W-1:0] idx,
    output logic             miss
);
    always_comb begin
        hit  = '0;
        idx  = '0;
        miss = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (((addr ^ BASE[i*32 +: 32]) & MASK[i*32 +: 32]) == 32'd0) begin
                hit    = '0;
                hit[i] = 1'b1;
                idx    = IDX_W'(i);
                miss   = 1'b0;
            end
        end
    end
endmodule

// File: rtl/bus_decoder_ctrl.sv
// bus_decoder_ctrl: registered address decoder and single-outstanding transaction controller
// with per-slave wait states, timeout watchdog and error capture for the CPU data port.
module bus_decoder_ctrl
    import bus_pkg::*;
#(
    parameter int                    NUM_SLV     = 5,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE    = {UART_BASE, TIMER_BASE, GPIO_BASE, TBMAN_BASE, DMEM_BASE},
    parameter logic [NUM_SLV*32-1:0] SLV_MASK    = {UART_MASK, TIMER_MASK, GPIO_MASK, TBMAN_MASK, DMEM_MASK},
    parameter int                    TIMEOUT_CYC = 16,
    parameter logic [31:0]           ERR_RDATA   = DEF_ERR_RDATA
) (
    input  logic                    clk,
    input  logic                    reset,
    bus_decoder_ctrl_if.slave       m,
    output logic [NUM_SLV-1:0]      s_cs_n,
    output logic                    s_we,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic [3:0]              s_be,
    input  logic [NUM_SLV*32-1:0]   s_rdata,
    input  logic [NUM_SLV-1:0]      s_ready,
    output logic [31:0]             err_addr,
    output logic [7:0]              err_cnt
);
    state_t state_q, state_d;
    logic [NUM_SLV-1:0] hit, cs_n_q, cs_n_d;
    logic [IDX_W-1:0]   idx, sel_q, sel_d;
    logic               miss, rdy, tmo, go;
    logic [31:0]        rd_sel;
    logic               s_we_q, s_we_d, m_err_q, m_err_d;
    logic [31:0]        s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
    logic [31:0]        m_rdata_q, m_rdata_d, err_addr_q, err_addr_d;
    logic [3:0]         s_be_q, s_be_d;
    logic [7:0]         err_cnt_q, err_cnt_d, tmo_q, tmo_d;

    region_match #(.N(NUM_SLV), .BASE(SLV_BASE), .MASK(SLV_MASK)) u_match (
        .addr(m.addr),
        .hit (hit),
        .idx (idx),
        .miss(miss)
    );

    // Only the selected slave's strobe and data matter; everything else is ignored.
    always_comb begin
        rdy    = 1'b0;
        rd_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q == IDX_W'(i)) begin
                rdy    = s_ready[i];
                rd_sel = s_rdata[i*32 +: 32];
            end
        end
    end

    assign tmo = tmo_q == 8'(TIMEOUT_CYC - 1);
    assign go  = (state_q == IDLE) && m.req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = m.req ? (miss ? RESP : ACCESS) : IDLE;
            ACCESS:  state_d = (rdy || tmo) ? RESP : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    // Ready wins over a timeout that lands on the same cycle.
    always_comb begin
        cs_n_d     = cs_n_q;
        sel_d      = sel_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_be_d     = s_be_q;
        m_rdata_d  = m_rdata_q;
        m_err_d    = m_err_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        tmo_d      = tmo_q;
        if (go && !miss) begin
            cs_n_d    = ~hit;
            sel_d     = idx;
            s_we_d    = m.we;
            s_addr_d  = m.addr;
            s_wdata_d = m.wdata;
            s_be_d    = m.be;
            tmo_d     = '0;
        end
        if (go && miss) begin
            m_err_d    = 1'b1;
            m_rdata_d  = ERR_RDATA;
            err_addr_d = m.addr;
            err_cnt_d  = sat_inc(err_cnt_q);
        end
        if (state_q == ACCESS) begin
            tmo_d = tmo_q + 8'd1;
            if (rdy || tmo) cs_n_d = '1;
            if (rdy) begin
                m_err_d   = 1'b0;
                m_rdata_d = s_we_q ? '0 : rd_sel;
            end else if (tmo) begin
                m_err_d    = 1'b1;
                m_rdata_d  = ERR_RDATA;
                err_addr_d = s_addr_q;
                err_cnt_d  = sat_inc(err_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n_q     <= '1;
            sel_q      <= '0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_be_q     <= '0;
            m_rdata_q  <= '0;
            m_err_q    <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
            tmo_q      <= '0;
        end else begin
            cs_n_q     <= cs_n_d;
            sel_q      <= sel_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_be_q     <= s_be_d;
            m_rdata_q  <= m_rdata_d;
            m_err_q    <= m_err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    assign m.ready  = state_q == RESP;
    assign m.rdata  = m_rdata_q;
    assign m.err    = m_err_q;
    assign s_cs_n   = cs_n_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_be     = s_be_q;
    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_bus_decoder_ctrl.sv
// tb_bus_decoder_ctrl: randomized and directed transactions checked every cycle against a
// per-cycle expectation schedule derived from the region table, wait counts and timeout rule.
module tb_bus_decoder_ctrl;
    localparam int NS  = 5;
    localparam int D   = 4096;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_decoder_ctrl_if m();
    logic [NS-1:0]    s_cs_n, s_ready;
    logic             s_we;
    logic [31:0]      s_addr, s_wdata, err_addr;
    logic [3:0]       s_be;
    logic [NS*32-1:0] s_rdata;
    logic [7:0]       err_cnt;

    bus_decoder_ctrl dut (
        .clk(clk), .reset(reset), .m(m),
        .s_cs_n(s_cs_n), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s_rdata(s_rdata), .s_ready(s_ready), .err_addr(err_addr), .err_cnt(err_cnt)
    );

    logic [31:0] base [NS] = '{32'h1000_0000, 32'h8000_F000, 32'h8000_2000, 32'h8000_1000, 32'h8000_0000};
    logic [31:0] mask [NS] = '{32'hD000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected behaviour for each clock interval (interval c follows posedge number c).
    logic [NS-1:0] exp_cs [D];
    logic          exp_rdy [D], exp_err [D], exp_swe [D];
    logic [31:0]   exp_rdata [D], exp_eaddr [D], exp_saddr [D], exp_swdata [D];
    logic [7:0]    exp_cnt [D];
    logic [3:0]    exp_sbe [D];

    int          a_min = 0, obs_rdy = 0, first_cs = 0, cs_len = 0;
    logic [7:0]  mcnt = 0;
    logic [31:0] meaddr = 0;
    int          w_cfg [NS], low_cnt [NS];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & mask[i]) == (base[i] & mask[i])) return i;
        return -1;
    endfunction

    // Slave models: selected slave answers after w_cfg cycles; unselected slaves chatter.
    initial begin
        s_ready = '0;
        for (int k = 0; k < NS; k++) begin w_cfg[k] = 0; low_cnt[k] = 0; end
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < NS; k++) begin
                if (!s_cs_n[k]) begin
                    s_ready[k] = (low_cnt[k] == w_cfg[k]);
                    low_cnt[k]++;
                end else begin
                    low_cnt[k] = 0;
                    s_ready[k] = 1'($urandom);
                end
            end
        end
    end

    logic [31:0]   hold_rd = 0;
    logic          hold_err = 0, prev_low = 0;
    logic [NS-1:0] last_cs = '1;
    always @(negedge clk) begin
        if (reset) begin
            hold_rd = 0; hold_err = 0; prev_low = 0;
        end else if (cyc < D) begin
            if (exp_rdy[cyc]) begin hold_rd = exp_rdata[cyc]; hold_err = exp_err[cyc]; end
            chk("cs_n", 32'(s_cs_n), 32'(exp_cs[cyc]));
            chk("m_ready", 32'(m.ready), 32'(exp_rdy[cyc]));
            chk("m_rdata", m.rdata, hold_rd);
            chk("m_err", 32'(m.err), 32'(hold_err));
            if (exp_rdy[cyc]) begin
                chk("err_cnt", 32'(err_cnt), 32'(exp_cnt[cyc]));
                chk("err_addr", err_addr, exp_eaddr[cyc]);
            end
            if (exp_cs[cyc] != '1) begin
                chk("s_addr", s_addr, exp_saddr[cyc]);
                chk("s_we", 32'(s_we), 32'(exp_swe[cyc]));
                chk("s_wdata", s_wdata, exp_swdata[cyc]);
                chk("s_be", 32'(s_be), 32'(exp_sbe[cyc]));
            end
            if (s_cs_n != '1) begin
                if (!prev_low) begin first_cs = cyc; cs_len = 0; last_cs = s_cs_n; end
                cs_len++;
                prev_low = 1;
            end else prev_low = 0;
        end
    end

    function automatic void sched_cs(input int from, input int len, input int k, input logic we,
                                     input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        for (int i = from; i < from + len; i++) begin
            exp_cs[i] = '1; exp_cs[i][k] = 1'b0;
            exp_saddr[i] = a; exp_swe[i] = we; exp_swdata[i] = wd; exp_sbe[i] = be;
        end
    endfunction

    // Called just after a posedge; returns just after the posedge of the response interval.
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input int w, input logic [31:0] rd, input bit hold, input bit drop);
        int k, n, r, len, g;
        logic [31:0] rdx;
        logic e;
        k = decode(a);
        n = (cyc + 1 > a_min) ? cyc + 1 : a_min;
        for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = $urandom;
        if (k < 0) begin
            r = n; e = 1'b1;
        end else begin
            w_cfg[k] = w;
            s_rdata[k*32 +: 32] = rd;
            len = (w < TMO) ? w + 1 : TMO;
            sched_cs(n, len, k, we, a, wd, be);
            r = n + len;
            e = (w >= TMO);
        end
        if (e) begin
            mcnt = (mcnt == 8'hFF) ? mcnt : mcnt + 8'd1;
            meaddr = a;
            rdx = 32'hDEAD_BEEF;
        end else rdx = we ? 32'h0 : rd;
        exp_rdy[r] = 1'b1; exp_rdata[r] = rdx; exp_err[r] = e; exp_cnt[r] = mcnt; exp_eaddr[r] = meaddr;
        a_min = r + 2;
        m.req = 1'b1; m.we = we; m.addr = a; m.wdata = wd; m.be = be;
        g = 0;
        do begin
            @(posedge clk); #1; g++;
            if (!m.ready && drop && k >= 0 && cyc >= n) m.req = 1'b0;
        end while (!m.ready && g < 64);
        if (!m.ready) begin
            total++; bad++;
            $display("FAIL txn_no_ready: got none want ready by cycle %0d", r);
        end
        obs_rdy = cyc;
        if (!hold) m.req = 1'b0;
    endtask

    initial begin
        int fc1, n, k, r;
        logic [31:0] a;
        m.req = 0; m.we = 0; m.addr = 0; m.wdata = 0; m.be = 0; s_rdata = '0;
        for (int i = 0; i < D; i++) begin
            exp_cs[i] = '1; exp_rdy[i] = 0; exp_err[i] = 0; exp_rdata[i] = 0; exp_cnt[i] = 0;
            exp_eaddr[i] = 0; exp_saddr[i] = 0; exp_swe[i] = 0; exp_swdata[i] = 0; exp_sbe[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(s_cs_n), 32'h1F);
        chk("rst_ready", 32'(m.ready), 0);
        chk("rst_rdata", m.rdata, 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_s_addr", s_addr, 0);
        reset = 0;
        a_min = cyc + 1;

        txn(0, 32'h8000_2004, 0, 4'hF, 0, 32'h0000_00A5, 0, 0);
        chk("gpio_rdata", m.rdata, 32'hA5);
        chk("gpio_cs", 32'(last_cs), 32'b11011);
        chk("gpio_lat", obs_rdy - first_cs, 1);

        txn(1, 32'h3000_0010, 32'hCAFE_1234, 4'b0011, 3, 32'h5555_AAAA, 0, 0);
        chk("dmem_cs", 32'(last_cs), 32'b11110);
        chk("dmem_lat", obs_rdy - first_cs, 4);
        chk("dmem_be", 32'(s_be), 32'b0011);
        chk("dmem_wdata", s_wdata, 32'hCAFE_1234);
        chk("dmem_rdata", m.rdata, 0);

        txn(0, 32'h4000_0000, 0, 4'hF, 0, 0, 0, 0);
        chk("miss_err", 32'(m.err), 1);
        chk("miss_rdata", m.rdata, 32'hDEAD_BEEF);
        chk("miss_eaddr", err_addr, 32'h4000_0000);
        chk("miss_cnt", 32'(err_cnt), 1);

        txn(0, 32'h8000_1008, 0, 4'hF, 40, 32'h1111_2222, 0, 0);
        chk("tmo_cs_len", cs_len, 16);
        chk("tmo_cs", 32'(last_cs), 32'b10111);
        chk("tmo_err", 32'(m.err), 1);
        chk("tmo_cnt", 32'(err_cnt), 2);
        chk("tmo_eaddr", err_addr, 32'h8000_1008);

        txn(0, 32'h8000_100C, 0, 4'hF, 15, 32'h3333_4444, 0, 0);
        chk("late_cs_len", cs_len, 16);
        chk("late_err", 32'(m.err), 0);
        chk("late_rdata", m.rdata, 32'h3333_4444);
        chk("late_cnt", 32'(err_cnt), 2);

        txn(0, 32'h8000_0040, 0, 4'hF, 0, 32'h0BAD_F00D, 1, 0);
        fc1 = first_cs;
        chk("b2b_uart_cs", 32'(last_cs), 32'b01111);
        txn(1, 32'h8000_F004, 32'h7777_8888, 4'b1100, 1, 0, 0, 0);
        chk("b2b_tbman_cs", 32'(last_cs), 32'b11101);
        chk("b2b_spacing_ge3", 32'((first_cs - fc1) >= 3), 1);

        for (int t = 0; t < 80; t++) begin
            int s, w;
            s = $urandom_range(0, 5);
            a = (s < NS) ? ((base[s] & mask[s]) | ($urandom & ~mask[s])) : $urandom;
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
            txn(1'($urandom), a, $urandom, 4'($urandom), w, $urandom,
                1'($urandom), $urandom_range(0, 3) == 0);
            if (m.req == 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // Reset in the middle of an access: select timer, then pull reset two cycles in.
        k = 3;
        a = 32'h8000_1010;
        n = (cyc + 1 > a_min) ? cyc + 1 : a_min;
        w_cfg[k] = 100;
        sched_cs(n, 3, k, 0, a, 32'h0, 4'hF);
        m.req = 1; m.we = 0; m.addr = a; m.wdata = 0; m.be = 4'hF;
        while (cyc < n + 2) begin @(posedge clk); #1; end
        for (int i = cyc; i < cyc + 40; i++) begin exp_cs[i] = '1; exp_rdy[i] = 0; end
        reset = 1;
        #1;
        chk("rst_mid_cs_n", 32'(s_cs_n), 32'h1F);
        chk("rst_mid_ready", 32'(m.ready), 0);
        chk("rst_mid_cnt", 32'(err_cnt), 0);
        m.req = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        mcnt = 0; meaddr = 0;
        a_min = cyc + 1;

        for (int t = 0; t < 300; t++) begin
            r = t;
            txn(0, 32'h4000_0000 | (r << 2), 0, 4'hF, 0, 0, 0, 0);
        end
        chk("sat_cnt", 32'(err_cnt), 32'hFF);
        chk("sat_err", 32'(m.err), 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
